// File: rtl/fir_sm_sink_pkg.sv
// fir_sink_pkg: register map addresses, STATUS bit indices and read FSM states for fir_sm_sink
package fir_sink_pkg;
  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_DATA   = 8'h04;
  localparam logic [7:0] ADDR_LENGTH = 8'h08;
  localparam logic [7:0] ADDR_RXCNT  = 8'h0C;
  localparam logic [7:0] ADDR_CTRL   = 8'h10;
  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_FDONE  = 2;
  localparam int ST_LENERR = 3;
  localparam int ST_UNDER  = 4;
  localparam int ST_COUNT  = 16;
  typedef enum logic {IDLE, RRESP} state_t;
endpackage

// File: rtl/fir_sm_sink_if.sv
// fir_sm_sink_if: sm_* stream plus AXI-Lite aw/w/ar/r channels; master = FIR/host side, slave = sink
interface fir_sm_sink_if #(parameter int pADDR_WIDTH = 12, parameter int pDATA_WIDTH = 32);
  logic                   sm_tvalid;
  logic                   sm_tready;
  logic                   sm_tlast;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;
  modport master (
    output sm_tvalid, sm_tlast, sm_tdata, awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  sm_tready, awready, wready, arready, rvalid, rdata
  );
  modport slave (
    input  sm_tvalid, sm_tlast, sm_tdata, awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output sm_tready, awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_sm_sink_fifo.sv
// sync_fifo: register-array FIFO (ports push/pop/flush/din in, full/empty/count/head out), pointers one bit wider than log2(DEPTH)
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  always_ff @(posedge clk)
    if (push) r_mem[r_wp[AW-1:0]] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (push) r_wp <= r_wp + 1'b1;
      if (pop)  r_rp <= r_rp + 1'b1;
    end
  assign count = r_wp - r_rp;
  assign empty = r_wp == r_rp;
  assign full  = count[AW];
  assign head  = r_mem[r_rp[AW-1:0]];
endmodule

// File: rtl/fir_sm_sink.sv
// fir_sm_sink: FIR stream sink (axis_clk/axis_rst, bus = sm_* + AXI-Lite slave, frame_done out) with FIFO, RXCNT, length check and sticky STATUS
module fir_sm_sink
  import fir_sink_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 16
) (
  input  logic          axis_clk,
  input  logic          axis_rst,
  fir_sm_sink_if.slave  bus,
  output logic          frame_done
);
  localparam int CW = $clog2(pDEPTH) + 1;
  state_t                 r_state;
  state_t                 w_next;
  logic                   r_alive;
  logic                   r_wpulse;
  logic                   r_fdone;
  logic                   r_lenerr;
  logic                   r_under;
  logic [pDATA_WIDTH-1:0] r_len;
  logic [pDATA_WIDTH-1:0] r_rxcnt;
  logic [pDATA_WIDTH-1:0] r_rdata;
  logic [pDATA_WIDTH-1:0] w_rdata;
  logic [pDATA_WIDTH-1:0] w_status;
  logic [pDATA_WIDTH-1:0] w_n;
  logic [pDATA_WIDTH-1:0] w_head;
  logic [CW-1:0]          w_count;
  logic [7:0]             w_waddr;
  logic [7:0]             w_raddr;
  logic                   w_wr;
  logic                   w_clr;
  logic                   w_rd;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_lerr;
  logic                   w_unused;
  assign w_unused = ^{bus.awaddr[pADDR_WIDTH-1:8], bus.araddr[pADDR_WIDTH-1:8]};
  assign w_waddr  = bus.awaddr[7:0];
  assign w_raddr  = bus.araddr[7:0];
  assign w_wr     = r_wpulse & bus.awvalid & bus.wvalid;
  assign w_clr    = w_wr & (w_waddr == ADDR_CTRL) & bus.wdata[0];
  assign w_rd     = bus.arvalid & r_alive & (r_state == IDLE);
  assign w_pop    = w_rd & (w_raddr == ADDR_DATA) & ~w_empty;
  assign w_push   = bus.sm_tvalid & bus.sm_tready & ~w_clr;
  assign w_n      = r_rxcnt + 1'b1;
  assign w_lerr   = r_fdone | ((r_len != '0) & (bus.sm_tlast ? w_n != r_len : w_n == r_len));
  assign bus.sm_tready = r_alive & ~w_full;
  assign bus.awready   = r_wpulse;
  assign bus.wready    = r_wpulse;
  assign bus.rdata     = r_rdata;
  assign frame_done    = r_fdone;
  sync_fifo #(.WIDTH(pDATA_WIDTH), .DEPTH(pDEPTH)) u_fifo (
    .clk   (axis_clk),
    .rst   (axis_rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_clr),
    .din   (bus.sm_tdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_head)
  );
  always_comb begin
    w_status              = '0;
    w_status[ST_EMPTY]    = w_empty;
    w_status[ST_FULL]     = w_full;
    w_status[ST_FDONE]    = r_fdone;
    w_status[ST_LENERR]   = r_lenerr;
    w_status[ST_UNDER]    = r_under;
    w_status[ST_COUNT+:9] = 9'(w_count);
  end
  always_comb
    w_rdata = w_raddr == ADDR_STATUS ? w_status :
              w_raddr == ADDR_DATA   ? (w_empty ? '0 : w_head) :
              w_raddr == ADDR_LENGTH ? r_len :
              w_raddr == ADDR_RXCNT  ? r_rxcnt : '0;
  always_comb begin
    bus.arready = r_alive & (r_state == IDLE);
    bus.rvalid  = r_state == RRESP;
    w_next      = r_state == IDLE ? (w_rd ? RRESP : IDLE) : (bus.rready ? IDLE : RRESP);
  end
  always_ff @(posedge axis_clk or posedge axis_rst)
    if (axis_rst) begin
      r_state <= IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_rd) r_rdata <= w_rdata;
    end
  always_ff @(posedge axis_clk or posedge axis_rst)
    if (axis_rst) begin
      r_alive  <= 1'b0;
      r_wpulse <= 1'b0;
      r_len    <= '0;
      r_rxcnt  <= '0;
      r_fdone  <= 1'b0;
      r_lenerr <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      r_alive  <= 1'b1;
      r_wpulse <= bus.awvalid & bus.wvalid & ~r_wpulse;
      if (w_wr && w_waddr == ADDR_LENGTH) r_len <= bus.wdata;
      if (w_clr) begin
        r_rxcnt  <= '0;
        r_fdone  <= 1'b0;
        r_lenerr <= 1'b0;
        r_under  <= 1'b0;
      end else begin
        if (w_push) begin
          r_rxcnt  <= w_n;
          r_fdone  <= r_fdone | bus.sm_tlast;
          r_lenerr <= r_lenerr | w_lerr;
        end
        if (w_rd && w_raddr == ADDR_DATA && w_empty) r_under <= 1'b1;
      end
    end
endmodule

// File: doc/fir_sm_sink.md
# fir_sm_sink

Downstream stage of the FIR engine. Accepts the FIR's AXI-Stream output (`sm_*`) into an internal FIFO and lets a host drain it over AXI-Lite. It also checks frame length against a programmed value and keeps a sample count and sticky status. It sits between the FIR `sm_*` master port and the host/testbench register bus.

## Interface
- `pADDR_WIDTH`, 12: AXI-Lite address width.
- `pDATA_WIDTH`, 32: sample and register width.
- `pDEPTH`, 16: FIFO depth in words; must be a power of two, 2..256.

Ports:
- `axis_clk` in 1: single clock for all logic.
- `axis_rst` in 1: asynchronous, active-high reset.
- `sm_tvalid` in 1: FIR output valid.
- `sm_tdata` in 32: FIR output sample, signed.
- `sm_tlast` in 1: last sample of frame.
- `sm_tready` out 1: sink can accept.
- `awvalid` in 1, `awready` out 1, `awaddr` in 12: write address channel.
- `wvalid` in 1, `wready` out 1, `wdata` in 32: write data channel.
- `arvalid` in 1, `arready` out 1, `araddr` in 12: read address channel.
- `rvalid` out 1, `rready` in 1, `rdata` out 32: read data channel.
- `frame_done` out 1: level copy of `STATUS[2]`.

## Operation
Register map (word addresses, `awaddr`/`araddr` bits [7:0]):
- 0x00 STATUS (RO):
  - [0] empty, [1] full
  - [2] frame_done (sticky), [3] length_error (sticky), [4] underflow (sticky)
  - [24:16] count (0..pDEPTH)
- 0x04 DATA (RO): returns the FIFO head and pops it. If the FIFO is empty, returns 0, does not pop, and sets underflow.
- 0x08 LENGTH (RW): expected samples per frame. Value 0 disables the length check.
- 0x0C RXCNT (RO): samples accepted since reset or clear. 32-bit, wraps.
- 0x10 CTRL (WO):
  - Writing bit0=1 flushes the FIFO and zeroes RXCNT and all sticky flags.
  - LENGTH is kept.
  - Reads of CTRL return 0.
- Unmapped reads return 0. Unmapped writes are ignored.

Stream acceptance:
- Accept when `sm_tvalid & sm_tready`.
- `sm_tready = ~full`; it is 0 while `axis_rst` is high.
- Each accept pushes `sm_tdata` and increments RXCNT.

Length check, applied at each accept while LENGTH≠0. Let n = RXCNT+1.
- `sm_tlast=1` and n≠LENGTH: set length_error.
- `sm_tlast=0` and n==LENGTH: set length_error.
- `sm_tlast=1`: set frame_done, whether or not the check is enabled.
- Any accept while frame_done=1: sample is still stored, and length_error is set.

## Timing
Reset values: `sm_tready`=0, `awready`=0, `wready`=0, `arready`=0, `rvalid`=0, `rdata`=0, `frame_done`=0. All registers are 0. Outputs reach their post-reset state on the first edge after deassertion: `arready`=1 and `sm_tready`=1.

Write channel:
- `awready` and `wready` pulse high together for exactly one cycle, in the cycle after both `awvalid` and `wvalid` are seen high.
- The register updates on that handshake edge.
- A new write can be accepted no sooner than two cycles later.

Read channel:
- `arready`=1 whenever no read is outstanding.
- On the `arvalid & arready` edge: `rdata` is registered, `rvalid` rises, `arready` drops, and a DATA pop takes effect.
- `rdata`/`rvalid` hold until `rvalid & rready`. `arready` returns to 1 on the next cycle.
- Read latency is 1 cycle.

FIFO:
- Push and pop in the same cycle: count unchanged, head and tail both advance.
- Full: `sm_tready` is already 0, so no push. A pop frees a slot and `sm_tready` returns to 1 the next cycle.
- STATUS reads return pre-edge values.

Clear:
- The CTRL clear takes effect on the write-handshake edge.
- A push in the same cycle is dropped and not counted.
- A DATA pop in the same cycle returns the old head, and the flush still applies.

Reset mid-operation: FIFO contents are discarded. Any outstanding `rvalid` drops immediately (asynchronous).

## Structure
- Package `fir_sink_pkg`: address constants ADDR_STATUS/DATA/LENGTH/RXCNT/CTRL and STATUS bit indices.
- Sub-module `sync_fifo`:
  - Parameters: width, depth.
  - Ports: push, pop, flush, full, empty, count, head.
  - Implemented as register array plus pointers one bit wider than log2(pDEPTH).
- Top level holds the AXI-Lite FSM with states IDLE → RRESP → IDLE, the write-pulse logic, and the length checker.

## Test plan
- **Basic drain:** LENGTH=4; stream 10, -20, 30, -40 with tlast on the 4th. Then:
  - STATUS reads count=4, frame_done=1, length_error=0.
  - Four DATA reads return 10, -20, 30, -40.
  - empty=1 afterwards.
- **Backpressure:** stream 17 samples with pDEPTH=16 and no reads. Then:
  - `sm_tready`=0 after the 16th accept; the 17th is held.
  - One DATA read returns sample 0; the 17th sample is accepted the cycle after `sm_tready` rises.
  - RXCNT=17.
- **Length errors:**
  - LENGTH=3 with tlast on the 2nd sample: length_error=1.
  - After clear, LENGTH=3 with no tlast on the 3rd sample: length_error=1.
  - LENGTH=0 with tlast on any sample: length_error=0.
- **Underflow:** DATA read with the FIFO empty: `rdata`=0, count stays 0, STATUS[4]=1. A CTRL write of 1 clears it to 0.
- **Simultaneous events and read hold:**
  - With count=5, a push and a DATA pop in the same cycle leave count=5 and keep order.
  - With `rready` held low 3 cycles, `rdata` stays stable and no second pop occurs.
- **Reset mid-stream:** pulse `axis_rst` with count=7 and a read outstanding. Then:
  - `rvalid`=0 immediately.
  - After release, STATUS=0x00000001 (empty) and RXCNT=0.
